audio_pwm_player: RTL



---
 rtl/audio_pkg.sv | 35 +++
 rtl/audio_pwm_core.sv | 42 ++++
 rtl/audio_pwm_player.sv | 135 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the PWM sample player.
// Latency: n/a (package only).
// Backpressure: n/a; the player is free-running once started.
//
// Contents: FSM state enum, default clock/sample-rate constants, derived
// clock divider and a configuration sanity check used at elaboration.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2
    } state_t;

    localparam int SYS_CLK_HZ = 100_000_000;
    localparam int SAMPLE_HZ  = 22050;

    function automatic int div_ceil(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Rounded up so the sample period never undershoots the target rate.
    localparam int DEF_CLK_DIV = div_ceil(SYS_CLK_HZ, SAMPLE_HZ);

    // The divider must be long enough to hold one full PWM window, and the
    // clip must fit in the ROM address space.
    function automatic bit cfg_ok(input int clk_div, input int sample_w,
                                  input int addr_w, input int length);
        return (longint'(clk_div) >= (longint'(1) << sample_w)) &&
               (clk_div >= 4) && (length >= 2) &&
               (longint'(length) <= (longint'(1) << addr_w));
    endfunction

endpackage

// File: rtl/audio_pwm_core.sv
`timescale 1ns/1ps
// PWM renderer: compares a free-running window counter against the sample.
// Latency: output registered, lags the compare by 1 cycle.
// Backpressure: none; runs whenever i_run is high, forced low otherwise.
//
// Ports: i_clk/i_rst clock and sync reset, i_run enables rendering (PLAY),
// i_restart clears the window counter at a sample-period boundary,
// i_sample is the attenuated sample, o_signal the registered PWM bit.
module audio_pwm_core
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_run,
    input  logic                i_restart,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic                o_signal
);

    logic [SAMPLE_W-1:0] r_pwm_cnt;
    logic                r_signal;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pwm_cnt <= '0;
            r_signal  <= 1'b0;
        end else if (!i_run) begin
            r_pwm_cnt <= '0;
            r_signal  <= 1'b0;
        end else begin
            r_signal  <= (r_pwm_cnt < i_sample);
            // Natural wrap repeats the window when the period is longer
            // than 2**SAMPLE_W; the restart realigns it to each sample.
            r_pwm_cnt <= i_restart ? '0 : r_pwm_cnt + SAMPLE_W'(1);
        end
    end

    assign o_signal = r_signal;

endmodule

// File: rtl/audio_pwm_player.sv
`timescale 1ns/1ps
// Streams PCM from a sync ROM and renders it as 1-bit PWM audio.
// Latency: Start in t -> FETCH t+1 -> PLAY t+2 -> first PWM high t+3.
// Backpressure: none; ROM is assumed to answer 1 cycle after the address.
//
// Ports: Master_Clock_In/Master_Reset_In clock and sync reset; Start_In,
// Stop_In, Loop_In, Volume_In playback control; Rom_Addr_Out/Rom_Data_In
// sample ROM interface; Signal_Out PWM pin; Playing_Out/Done_Out status.
module audio_pwm_player
    import audio_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int SAMPLE_W = 8,
    parameter int ADDR_W   = 16,
    parameter int LENGTH   = 65536
) (
    input  logic                Master_Clock_In,
    input  logic                Master_Reset_In,
    input  logic                Start_In,
    input  logic                Stop_In,
    input  logic                Loop_In,
    input  logic [1:0]          Volume_In,
    output logic [ADDR_W-1:0]   Rom_Addr_Out,
    input  logic [SAMPLE_W-1:0] Rom_Data_In,
    output logic                Signal_Out,
    output logic                Playing_Out,
    output logic                Done_Out
);

    if (!cfg_ok(CLK_DIV, SAMPLE_W, ADDR_W, LENGTH)) begin : g_bad_cfg
        $error("audio_pwm_player: CLK_DIV/SAMPLE_W/ADDR_W/LENGTH inconsistent");
    end

    localparam int                DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LENGTH - 1);
    localparam logic [ADDR_W:0]   LEN_EXT  = (ADDR_W + 1)'(LENGTH);

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_done;

    logic                w_period_end;
    logic [ADDR_W:0]     w_idx_p2;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [SAMPLE_W-1:0] w_scaled;

    assign w_period_end = (r_state == PLAY) && (r_div == DIV_LAST);
    assign w_scaled     = Rom_Data_In >> Volume_In;

    // Prefetch two ahead of the sample being played; one extra bit so the
    // compare against LENGTH works when LENGTH == 2**ADDR_W. Wrapping to 0
    // keeps the first sample ready for a seamless loop.
    assign w_idx_p2    = {1'b0, r_idx} + (ADDR_W + 1)'(2);
    assign w_next_addr = (w_idx_p2 == LEN_EXT) ? '0 : w_idx_p2[ADDR_W-1:0];

    always_ff @(posedge Master_Clock_In) begin
        if (Master_Reset_In) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_idx    <= '0;
            r_addr   <= '0;
            r_sample <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_div  <= '0;
                    r_addr <= '0;
                    if (Start_In && !Stop_In) begin
                        r_state <= FETCH;
                        r_idx   <= '0;
                    end
                end
                FETCH: begin
                    if (Stop_In) begin
                        r_state <= IDLE;
                        r_addr  <= '0;
                    end else begin
                        r_sample <= w_scaled;
                        r_addr   <= ADDR_W'(1);
                        r_div    <= '0;
                        r_state  <= PLAY;
                    end
                end
                PLAY: begin
                    if (Stop_In) begin
                        r_state <= IDLE;
                        r_addr  <= '0;
                        r_div   <= '0;
                    end else if (r_div != DIV_LAST) begin
                        r_div <= r_div + DIV_W'(1);
                    end else begin
                        r_div <= '0;
                        if (r_idx != LAST_IDX) begin
                            r_sample <= w_scaled;
                            r_idx    <= r_idx + ADDR_W'(1);
                            r_addr   <= w_next_addr;
                        end else if (Loop_In) begin
                            // Address 0 was prefetched during the last sample.
                            r_sample <= w_scaled;
                            r_idx    <= '0;
                            r_addr   <= ADDR_W'(1);
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_addr  <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    audio_pwm_core #(
        .SAMPLE_W (SAMPLE_W)
    ) u_core (
        .i_clk     (Master_Clock_In),
        .i_rst     (Master_Reset_In),
        .i_run     (r_state == PLAY),
        .i_restart (w_period_end),
        .i_sample  (r_sample),
        .o_signal  (Signal_Out)
    );

    assign Rom_Addr_Out = r_addr;
    assign Playing_Out  = (r_state != IDLE);
    assign Done_Out     = r_done;

endmodule
